seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector: the configurable successor to the fixed-state sequence-detector FSMs in this codebase. It watches a 1-bit input stream qualified by `in_valid` and matches it against a run-time-loadable pattern of 1..`PAT_W` bits. It supports overlapping and non-overlapping match modes and emits a registered one-cycle match pulse. It also keeps a saturating match counter, and sits between the stimulus/bit-serialiser and the scoring/monitor logic.

## Interface
Parameters:
- `PAT_W`, default 4: maximum pattern length in bits (legal 2..16).
- `CNT_W`, default 8: match counter width.
- `DEFAULT_PAT`, default 4'b1011: pattern loaded at reset (`PAT_W` bits).
- `DEFAULT_OVERLAP`, default 1: overlap mode after reset.

Ports (LEN_W = $clog2(PAT_W)+1):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `i` carries a stream bit this cycle.
- `i`  in  1  serial stream bit.
- `cfg_load`  in  1  latch `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  PAT_W  new pattern; bit `[len-1]` is the first bit received, bit 0 the last.
- `cfg_len`  in  LEN_W  active pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`  in  1  clear the match counter.
- `out`  out  1  match pulse, registered, one cycle wide per match.
- `match_count`  out  CNT_W  saturating count of matches.
- `fill`  out  LEN_W  number of valid history bits, saturating at `len` (debug/observability).

## Operation
- State:
  - history shift register `hist[PAT_W-1:0]`
  - fill counter
  - configuration registers `pat`, `len`, `ovl`
  - `out` register and counter.
- Accepted bit (`in_valid`=1, `cfg_load`=0):
  - `hist <= {hist[PAT_W-2:0], i}`.
  - `fill <= min(fill+1, len)`.
- Match condition, evaluated on the post-shift history:
  - `fill_next == len`, and
  - `hist_next[len-1:0] == pat[len-1:0]`.
  - Bits above `len` are ignored.
- On a match:
  - `out <= 1` for exactly one cycle.
  - `match_count` increments.
  - If `ovl`=0, `fill <= 0`, so the next match needs `len` fresh bits.
  - If `ovl`=1, `fill` stays at `len`.
- No accepted bit (`in_valid`=0): `hist` and `fill` hold, and `out <= 0`.
- Config load (`cfg_load`=1):
  - Latches `pat`, `ovl` and `len`.
  - `len` is clamped: 0 becomes 1, and values greater than `PAT_W` become `PAT_W`.
  - Clears `fill` to 0 and sets `out <= 0`.
  - `hist` contents are don't-care; `match_count` is preserved.
  - A stream bit presented in the same cycle is discarded.
- Counter:
  - Saturates at 2^CNT_W-1; it never wraps.
  - `cnt_clr` alone sets it to 0.
  - `cnt_clr` in the same cycle as a match sets it to 1: clear first, then count.
- Reset (`rst`=1 at an edge) overrides every other input. It sets:
  - `pat`=`DEFAULT_PAT`, `len`=`PAT_W`, `ovl`=`DEFAULT_OVERLAP`
  - `hist`=0, `fill`=0, `out`=0, `match_count`=0.

## Timing
- Latency: the bit completing a pattern is sampled at edge k; `out`=1 during the cycle after edge k and falls at edge k+1 unless edge k+1 also matches.
- Back-to-back matches are possible in overlap mode (e.g. pattern 11, stream 1,1,1 gives `out` high for two consecutive cycles).
- `match_count` and `fill` update at the same edge as `out` rises.
- Reset mid-stream: the partial match is lost, and detection restarts needing `len` new bits.
- New configuration takes effect for the first bit accepted after the `cfg_load` edge.

## Test plan
- Reset, then default pattern 1011 (`len` 4, overlap): stream 1,0,1,1,0,1,1 with `in_valid`=1 -> `out` pulses after bits 4 and 7; `match_count`=2.
- Load pattern 101, `len`=3, `cfg_overlap`=1, stream 1,0,1,0,1 -> pulses after bits 3 and 5. Repeat with `cfg_overlap`=0 -> single pulse after bit 3; `match_count` +1.
- Gaps: pattern 1011 sent with `in_valid` low for 3 cycles between bits 2 and 3 -> exactly one pulse, one cycle after bit 4 is accepted; `out` stays 0 during the gaps.
- `cfg_load` with `cfg_len`=0 and pattern bit0=1, then stream 0,1 -> pulse after the 1 only (`len` clamped to 1). `cfg_len`=7 with `PAT_W`=4 -> behaves as `len` 4.
- Counter: `CNT_W`=2, pattern 11 overlap, stream of six 1s -> `match_count` saturates at 3. Assert `cnt_clr` in a matching cycle -> `match_count`=1.
- Reset after bits 1,0,1 of 1011, then stream 1 -> no pulse; a full 1,0,1,1 afterwards -> one pulse; all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable pattern of 1..PAT_W bits,
// overlap/non-overlap modes, a registered match pulse and a saturating match counter.
module seq_detector_param #(
    parameter int               PAT_W           = 4,
    parameter int               CNT_W           = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT     = PAT_W'(4'b1011),
    parameter bit               DEFAULT_OVERLAP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    i,
    input  logic                    cfg_load,
    input  logic [PAT_W-1:0]        cfg_pattern,
    input  logic [$clog2(PAT_W):0]  cfg_len,
    input  logic                    cfg_overlap,
    input  logic                    cnt_clr,
    output logic                    out,
    output logic [CNT_W-1:0]        match_count,
    output logic [$clog2(PAT_W):0]  fill
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;

    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    logic [LEN_W-1:0] len_clamp;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             match;

    assign hist_next = {hist[PAT_W-2:0], i};
    assign fill_inc  = (fill >= len) ? len : fill + LEN_W'(1);

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int b = 0; b < PAT_W; b++)
            mask[b] = (b < int'(len));
    end

    assign match = in_valid && !cfg_load && (fill_inc == len)
                   && (((hist_next ^ pat) & mask) == '0);

    always_comb begin
        len_clamp = cfg_len;
        if (cfg_len == '0)
            len_clamp = LEN_W'(1);
        else if (cfg_len > LEN_MAX)
            len_clamp = LEN_MAX;
    end

    // Clear takes effect before a same-cycle match is counted.
    assign cnt_base = cnt_clr ? '0 : match_count;
    assign cnt_next = (match && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat         <= DEFAULT_PAT;
            len         <= LEN_MAX;
            ovl         <= DEFAULT_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else begin
            match_count <= cnt_next;
            if (cfg_load) begin
                pat  <= cfg_pattern;
                len  <= len_clamp;
                ovl  <= cfg_overlap;
                fill <= '0;
                out  <= 1'b0;
            end else if (in_valid) begin
                hist <= hist_next;
                out  <= match;
                fill <= (match && !ovl) ? '0 : fill_inc;
            end else begin
                out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2) with hand-computed expectations.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       i;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       out;
    logic [1:0] match_count;
    logic [2:0] fill;

    int n_assert = 0;
    int n_fail   = 0;

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i(i),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out), .match_count(match_count), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; i = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    endtask

    // Bits and expected out pulses are given MSB-first (first bit sent = bits[n-1]).
    task automatic send(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp_out);
        for (int k = n - 1; k >= 0; k--) begin
            in_valid = 1'b1;
            i        = bits[k];
            tick();
            chk($sformatf("%s_out_bit%0d", tag, n - k), {31'b0, out}, {31'b0, exp_out[k]});
        end
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] p, input logic [2:0] l, input logic o,
                        input logic clr);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clr = clr;
        in_valid = 1'b1; i = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        cfg_pattern = 4'b0; cfg_len = 3'd0; cfg_overlap = 1'b0;

        // Reset state
        rst = 1'b1; in_valid = 1'b1; i = 1'b1;
        tick(); tick();
        idle();
        chk("rst_out", {31'b0, out}, 32'd0);
        chk("rst_cnt", {30'b0, match_count}, 32'd0);
        chk("rst_fill", {29'b0, fill}, 32'd0);

        // Default pattern 1011, overlap
        send("dflt", 7, 16'b1011011, 16'b0001001);
        chk("dflt_cnt", {30'b0, match_count}, 32'd2);
        chk("dflt_fill", {29'b0, fill}, 32'd4);
        tick();
        chk("idle_out", {31'b0, out}, 32'd0);

        cnt_clr = 1'b1; tick(); idle();
        chk("clr_cnt", {30'b0, match_count}, 32'd0);

        // Pattern 101 overlap; the bit presented with cfg_load is dropped
        load(4'b0101, 3'd3, 1'b1, 1'b0);
        chk("ld_fill", {29'b0, fill}, 32'd0);
        chk("ld_out", {31'b0, out}, 32'd0);
        send("p101o", 5, 16'b10101, 16'b00101);
        chk("p101o_cnt", {30'b0, match_count}, 32'd2);

        // Same pattern, non-overlap
        load(4'b0101, 3'd3, 1'b0, 1'b0);
        send("p101n", 5, 16'b10101, 16'b00100);
        chk("p101n_cnt", {30'b0, match_count}, 32'd3);
        chk("p101n_fill", {29'b0, fill}, 32'd2);

        // Gaps in in_valid between bits 2 and 3
        load(4'b1011, 3'd4, 1'b1, 1'b1);
        chk("gap_clr_cnt", {30'b0, match_count}, 32'd0);
        send("gapA", 2, 16'b10, 16'b00);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("gap_idle%0d_out", g), {31'b0, out}, 32'd0);
            chk($sformatf("gap_idle%0d_fill", g), {29'b0, fill}, 32'd2);
        end
        send("gapB", 2, 16'b11, 16'b01);
        tick();
        chk("gap_after_out", {31'b0, out}, 32'd0);
        chk("gap_cnt", {30'b0, match_count}, 32'd1);

        // len 0 clamps to 1, pattern bit0 = 1
        load(4'b0001, 3'd0, 1'b1, 1'b0);
        send("len0", 2, 16'b01, 16'b01);
        chk("len0_fill", {29'b0, fill}, 32'd1);
        chk("len0_cnt", {30'b0, match_count}, 32'd2);

        // len 7 clamps to 4
        load(4'b1011, 3'd7, 1'b1, 1'b0);
        send("len7", 4, 16'b1011, 16'b0001);
        chk("len7_fill", {29'b0, fill}, 32'd4);
        chk("len7_cnt", {30'b0, match_count}, 32'd3);

        // Counter saturation with pattern 11
        load(4'b0011, 3'd2, 1'b1, 1'b1);
        send("sat", 6, 16'b111111, 16'b011111);
        chk("sat_cnt", {30'b0, match_count}, 32'd3);
        cnt_clr = 1'b1;
        send("clrmatch", 1, 16'b1, 16'b1);
        cnt_clr = 1'b0;
        chk("clrmatch_cnt", {30'b0, match_count}, 32'd1);
        cnt_clr = 1'b1; tick(); idle();
        chk("clr_only_cnt", {30'b0, match_count}, 32'd0);

        // Reset mid-stream loses the partial match
        load(4'b1011, 3'd4, 1'b1, 1'b0);
        send("prer", 3, 16'b101, 16'b000);
        rst = 1'b1; in_valid = 1'b1; i = 1'b1; cnt_clr = 1'b0;
        tick();
        idle();
        chk("midrst_out", {31'b0, out}, 32'd0);
        chk("midrst_cnt", {30'b0, match_count}, 32'd0);
        chk("midrst_fill", {29'b0, fill}, 32'd0);
        send("postr", 5, 16'b11011, 16'b00001);
        chk("postr_cnt", {30'b0, match_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
